mmio_port_bridge: RTL and testbench
===================================

// Module: mmio_port_bridge
// PURPOSE
//  Memory-mapped I/O bridge directly downstream of the ALU/register-file store path, alongside DataMemory.
//  Decodes ALUResult as the address and steers loads/stores either to DataMemory or to 4 I/O registers.
//  Owns PortOut, a synchronised PortIn with sticky change flag, and a byte TX FIFO with valid/ready drain.
//  Load data is combinational (unicycle), side effects commit on the clock edge.
// PARAMETERS
//  IO_BASE      32'hFFFF_0000  I/O window base; window = IO_BASE[31:4] match (16 bytes)
//  TX_DEPTH     4              TX FIFO entries; power of 2, 2..16
//  SYNC_STAGES  2              flip-flop stages on PortIn, >=2
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low; clears all state immediately
//  Address      in   32  byte address (ALUResult)
//  WriteData    in   32  store data (ReadData2)
//  MemWrite     in   1   store strobe from Control
//  MemRead      in   1   load strobe from Control
//  DM_ReadData  in   32  read data returned by DataMemory
//  DM_MemWrite  out  1   MemWrite & ~io_sel, to DataMemory
//  DM_MemRead   out  1   MemRead & ~io_sel, to DataMemory
//  ReadData     out  32  io_sel ? io_rdata : DM_ReadData (to MemtoReg mux)
//  PortIn       in   8   asynchronous external input
//  PortOut      out  32  output port register
//  TxData       out  8   FIFO head byte
//  TxValid      out  1   FIFO non-empty
//  TxReady      in   1   consumer accepts head when TxValid & TxReady at clk edge
// BEHAVIOUR
//  io_sel = (Address[31:4] == IO_BASE[31:4]); register index = Address[3:2]; Address[1:0] ignored.
//  Map: 0 PORTOUT (RW) | 1 PORTIN (RO) | 2 STATUS (RO, read-to-clear) | 3 TXDATA (WO).
//  Reads of WO/illegal return 0; writes to RO registers ignored; no error.
//  PORTOUT: MemWrite&io_sel&idx0 -> PortOut <= WriteData next edge; readback = PortOut.
//  PORTIN: read = {24'b0, pin_sync}; pin_sync = PortIn after SYNC_STAGES flops (latency SYNC_STAGES edges).
//  CHG sticky: set on edge where pin_sync changes value; cleared on edge where MemRead&io_sel&idx2.
//  STATUS read = {16'b0, count[7:0], 4'b0, OVF, EMPTY, FULL, CHG}; count = FIFO occupancy 0..TX_DEPTH.
//  Set beats clear: change detected same edge as STATUS read -> CHG stays 1 (likewise OVF).
//  TXDATA: MemWrite&io_sel&idx3 pushes WriteData[7:0]. Push when full and no pop: byte dropped, OVF<=1.
//  Push+pop same edge: both occur, count unchanged; when full, push accepted (no OVF).
//  Pop: TxValid&TxReady at edge -> read ptr advances; TxData shows new head same cycle after edge.
//  Empty: TxValid=0, TxData=0 (not stale). Pointers wrap modulo TX_DEPTH, extra MSB distinguishes full/empty.
//  MemRead and MemWrite both high: write committed, read data still valid combinationally.
//  Reset values (async, any time incl. mid-transfer): PortOut=0, FIFO empty (ptrs 0), TxValid=0, TxData=0,
//   CHG=0, OVF=0, sync flops=0. Entries in flight are discarded; no pop in reset cycle.
//  DM_MemWrite/DM_MemRead are never asserted for io_sel addresses; non-I/O accesses pass through unchanged.
// STRUCTURE
//  Shared header mips_io_defs.vh: IO register index localparams (PORTOUT=0,PORTIN=1,STATUS=2,TXDATA=3),
//   STATUS bit positions, default IO_BASE.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH=TX_DEPTH): push/pop/full/empty/count, reset same as top.
//  Top holds decode, PortOut reg, synchroniser, sticky flags, read mux.
// TESTING
//  Reset release, sw 0xDEADBEEF to IO_BASE+0 -> PortOut=0xDEADBEEF next edge, lw IO_BASE+0 returns it, DM_MemWrite=0.
//  sw/lw 0x1001_0004 -> DM_MemWrite/DM_MemRead=1, ReadData=DM_ReadData, PortOut unchanged.
//  PortIn 0x00->0x5A -> PORTIN reads 0x5A after 2 edges, STATUS bit0=1; lw STATUS -> next read bit0=0.
//  TxReady=0, sw 0x11,0x22,0x33,0x44,0x55 to TXDATA -> FULL=1, count=4, OVF=1, 0x55 dropped;
//   then TxReady=1 -> TxData 0x11,0x22,0x33,0x44 on 4 edges, TxValid=0 after.
//  FIFO full, push 0x66 with TxReady=1 same edge -> count stays 4, OVF stays 0, 0x66 is last out.
//  Assert reset low mid-drain with count=3 -> TxValid=0, PortOut=0, STATUS=0x0004 immediately (async).

Source files
------------

// File: rtl/mmio_port_bridge_pkg.sv
// Shared definitions for the MMIO port bridge: register map, STATUS layout,
// default I/O window base.
package mmio_port_bridge_pkg;

   localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_0000;

   typedef enum logic [1:0] {
      REG_PORTOUT = 2'd0,
      REG_PORTIN  = 2'd1,
      REG_STATUS  = 2'd2,
      REG_TXDATA  = 2'd3
   } io_reg_e;

   localparam int ST_CHG   = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 8;

   function automatic logic [31:0] status_word(
      input logic [7:0] cnt,
      input logic       ovf,
      input logic       empty,
      input logic       full,
      input logic       chg
   );
      return {16'b0, cnt, 4'b0, ovf, empty, full, chg};
   endfunction

endpackage

// File: rtl/mmio_port_bridge_sync_fifo.sv
// Byte FIFO with extra-MSB pointers; head is masked to zero while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       din_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   assign count_o = wptr_q - rptr_q;
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i & ~empty_o;
   // A simultaneous pop frees the slot, so a full FIFO still accepts.
   assign push_ok = push_i & (~full_o | pop_ok);
   assign dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/mmio_port_bridge.sv
// Steers loads/stores between DataMemory and four I/O registers:
// PortOut, synchronised PortIn, read-to-clear STATUS, TX byte FIFO.
module mmio_port_bridge
   import mmio_port_bridge_pkg::*;
#(
   parameter logic [31:0] IO_BASE     = IO_BASE_DEF,
   parameter int          TX_DEPTH    = 4,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] DM_ReadData,
   output logic        DM_MemWrite,
   output logic        DM_MemRead,
   output logic [31:0] ReadData,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic [7:0]  TxData,
   output logic        TxValid,
   input  logic        TxReady
);

   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic                           io_sel;
   io_reg_e                        idx;
   logic                           wr_io;
   logic                           rd_io;
   logic [31:0]                    portout_q, portout_d;
   logic [SYNC_STAGES-1:0][7:0]    sync_q;
   logic [7:0]                     pin_sync;
   logic                           chg_q, chg_d;
   logic                           ovf_q, ovf_d;
   logic                           chg_set;
   logic                           ovf_set;
   logic                           stat_clr;
   logic                           tx_push;
   logic                           tx_pop;
   logic                           tx_full;
   logic                           tx_empty;
   logic [CW-1:0]                  tx_count;
   logic [31:0]                    io_rdata;
   logic                           unused_addr;

   assign io_sel      = (Address[31:4] == IO_BASE[31:4]);
   assign idx         = io_reg_e'(Address[3:2]);
   assign unused_addr = ^Address[1:0];
   assign wr_io       = MemWrite & io_sel;
   assign rd_io       = MemRead & io_sel;
   assign DM_MemWrite = MemWrite & ~io_sel;
   assign DM_MemRead  = MemRead & ~io_sel;

   assign pin_sync = sync_q[SYNC_STAGES-1];
   assign chg_set  = (sync_q[SYNC_STAGES-2] != pin_sync);
   assign stat_clr = rd_io & (idx == REG_STATUS);
   assign tx_push  = wr_io & (idx == REG_TXDATA);
   assign tx_pop   = TxValid & TxReady;
   assign ovf_set  = tx_push & tx_full & ~tx_pop;
   assign TxValid  = ~tx_empty;
   assign PortOut  = portout_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (tx_push),
      .din_i   (WriteData[7:0]),
      .pop_i   (tx_pop),
      .dout_o  (TxData),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count)
   );

   // Clear first so a same-edge set wins.
   always_comb begin
      portout_d = portout_q;
      chg_d     = chg_q;
      ovf_d     = ovf_q;
      if (wr_io && idx == REG_PORTOUT) portout_d = WriteData;
      if (stat_clr) begin
         chg_d = 1'b0;
         ovf_d = 1'b0;
      end
      if (chg_set) chg_d = 1'b1;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         portout_q <= '0;
         sync_q    <= '0;
         chg_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         portout_q <= portout_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], PortIn};
         chg_q     <= chg_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      io_rdata = '0;
      unique case (idx)
         REG_PORTOUT: io_rdata = portout_q;
         REG_PORTIN:  io_rdata = {24'b0, pin_sync};
         REG_STATUS:  io_rdata = status_word(8'(tx_count), ovf_q,
                                             tx_empty, tx_full, chg_q);
         REG_TXDATA:  io_rdata = '0;
      endcase
   end

   assign ReadData = io_sel ? io_rdata : DM_ReadData;

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Bench for mmio_port_bridge: decode vector table, PortIn/STATUS sequences,
// TX FIFO scoreboard, async reset mid-drain.
module tb_mmio_port_bridge;
   import mmio_port_bridge_pkg::*;

   localparam logic [31:0] IOB = 32'hFFFF_0000;
   localparam int          TXD = 4;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] DM_ReadData;
   logic        DM_MemWrite;
   logic        DM_MemRead;
   logic [31:0] ReadData;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic [7:0]  TxData;
   logic        TxValid;
   logic        TxReady;

   mmio_port_bridge #(
      .IO_BASE     (IOB),
      .TX_DEPTH    (TXD),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Address     (Address),
      .WriteData   (WriteData),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .DM_ReadData (DM_ReadData),
      .DM_MemWrite (DM_MemWrite),
      .DM_MemRead  (DM_MemRead),
      .ReadData    (ReadData),
      .PortIn      (PortIn),
      .PortOut     (PortOut),
      .TxData      (TxData),
      .TxValid     (TxValid),
      .TxReady     (TxReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic        we;
      logic        re;
      logic [31:0] dm;
      logic [31:0] x_rd;
      logic        x_dmw;
      logic        x_dmr;
      logic [31:0] x_po;
   } vec_t;

   vec_t       tbl [12];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] sb_q [$];
   logic       m_ovf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic re,
                        input logic [31:0] dm);
      Address     = a;
      WriteData   = wd;
      MemWrite    = we;
      MemRead     = re;
      DM_ReadData = dm;
      #1;
   endtask

   function automatic logic [31:0] exp_stat(input logic chg);
      return {16'b0, 8'(sb_q.size()), 4'b0, m_ovf,
              sb_q.size() == 0, sb_q.size() == TXD, chg};
   endfunction

   // Compare TX handshake before the edge, update the model, advance.
   task automatic step();
      logic       popm;
      logic       io;
      logic       push;
      logic [7:0] exp_b;
      popm = (sb_q.size() != 0) && TxReady;
      io   = (Address[31:4] == IOB[31:4]);
      push = MemWrite && io && (Address[3:2] == 2'd3);
      chk("tx_valid", 32'(TxValid), 32'(sb_q.size() != 0));
      if (sb_q.size() == 0) chk("tx_data_empty", 32'(TxData), 32'h0);
      if (popm) begin
         exp_b = sb_q.pop_front();
         chk("tx_data", 32'(TxData), 32'(exp_b));
      end
      if (MemRead && io && Address[3:2] == 2'd2) m_ovf = 1'b0;
      if (push) begin
         if (sb_q.size() < TXD) sb_q.push_back(WriteData[7:0]);
         else m_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{IOB,          32'hDEADBEEF, 1, 0, 32'h0,
                  32'h0,        0, 0, 32'h0};
      tbl[1]  = '{IOB,          32'h0,        0, 1, 32'h11111111,
                  32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
      tbl[2]  = '{32'h10010004, 32'h12345678, 1, 0, 32'hCAFEF00D,
                  32'hCAFEF00D, 1, 0, 32'hDEADBEEF};
      tbl[3]  = '{32'h10010004, 32'h0,        0, 1, 32'hA5A5A5A5,
                  32'hA5A5A5A5, 0, 1, 32'hDEADBEEF};
      tbl[4]  = '{IOB + 32'h3,  32'h0,        0, 1, 32'h0,
                  32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
      tbl[5]  = '{IOB + 32'hC,  32'h0,        0, 1, 32'h99999999,
                  32'h0,        0, 0, 32'hDEADBEEF};
      tbl[6]  = '{IOB + 32'h4,  32'hFFFFFFFF, 1, 0, 32'h0,
                  32'h0,        0, 0, 32'hDEADBEEF};
      tbl[7]  = '{IOB + 32'h4,  32'h0,        0, 1, 32'h0,
                  32'h0,        0, 0, 32'hDEADBEEF};
      tbl[8]  = '{32'hFFFF0010, 32'h0,        0, 1, 32'h13579BDF,
                  32'h13579BDF, 0, 1, 32'hDEADBEEF};
      tbl[9]  = '{32'hFFFEFFFC, 32'h1,        1, 0, 32'h2468ACE0,
                  32'h2468ACE0, 1, 0, 32'hDEADBEEF};
      tbl[10] = '{IOB,          32'h0BADF00D, 1, 1, 32'h0,
                  32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
      tbl[11] = '{IOB,          32'h0,        0, 1, 32'h0,
                  32'h0BADF00D, 0, 0, 32'h0BADF00D};

      reset   = 1'b0;
      PortIn  = 8'h00;
      TxReady = 1'b0;
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      #2;
      chk("rst_portout", PortOut, 32'h0);
      chk("rst_txvalid", 32'(TxValid), 32'h0);
      chk("rst_txdata", 32'(TxData), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(IOB + 32'h8, 32'h0, 0, 1, 32'h0);
      chk("rst_status", ReadData, 32'h0000_0004);
      step();

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].addr, tbl[i].wd, tbl[i].we, tbl[i].re, tbl[i].dm);
         chk($sformatf("vec%0d_rdata", i), ReadData, tbl[i].x_rd);
         chk($sformatf("vec%0d_dmw", i), 32'(DM_MemWrite), 32'(tbl[i].x_dmw));
         chk($sformatf("vec%0d_dmr", i), 32'(DM_MemRead), 32'(tbl[i].x_dmr));
         chk($sformatf("vec%0d_portout", i), PortOut, tbl[i].x_po);
         step();
      end

      PortIn = 8'h5A;
      drive(IOB + 32'h4, 32'h0, 0, 1, 32'h0);
      chk("portin_e0", ReadData, 32'h0);
      step();
      chk("portin_e1", ReadData, 32'h0);
      step();
      chk("portin_e2", ReadData, 32'h5A);
      drive(IOB + 32'h8, 32'h0, 0, 1, 32'h0);
      chk("status_chg", ReadData, exp_stat(1'b1));
      step();
      chk("status_chg_clr", ReadData, exp_stat(1'b0));

      PortIn = 8'hA5;
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      step();
      drive(IOB + 32'h8, 32'h0, 0, 1, 32'h0);
      chk("status_pre_set", ReadData, exp_stat(1'b0));
      step();
      chk("status_set_wins", ReadData, exp_stat(1'b1));
      step();
      chk("status_clr2", ReadData, exp_stat(1'b0));

      TxReady = 1'b0;
      foreach (tbl[i]) begin
         if (i < 5) begin
            drive(IOB + 32'hC, 32'(8'h11 * (i + 1)), 1, 0, 32'h0);
            step();
         end
      end
      drive(IOB + 32'h8, 32'h0, 0, 1, 32'h0);
      chk("status_full_ovf", ReadData, exp_stat(1'b0));
      chk("status_full_ovf_k", ReadData, 32'h0000_040A);
      step();
      chk("status_ovf_clr", ReadData, exp_stat(1'b0));

      TxReady = 1'b1;
      drive(IOB + 32'hC, 32'h66, 1, 0, 32'h0);
      step();
      TxReady = 1'b0;
      drive(IOB + 32'h8, 32'h0, 0, 1, 32'h0);
      chk("status_pushpop", ReadData, 32'h0000_0402);
      step();
      TxReady = 1'b1;
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
      chk("tx_drain_left", 32'(sb_q.size()), 32'h0);
      chk("tx_valid_drained", 32'(TxValid), 32'h0);
      chk("tx_data_drained", 32'(TxData), 32'h0);

      TxReady = 1'b0;
      drive(IOB, 32'h77, 1, 0, 32'h0);
      step();
      for (int k = 0; k < 4; k++) begin
         drive(IOB + 32'hC, 32'(8'hA1 + k), 1, 0, 32'h0);
         step();
      end
      TxReady = 1'b1;
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      chk("pre_rst_portout", PortOut, 32'h77);
      step();
      chk("pre_rst_count", 32'(sb_q.size()), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_txvalid", 32'(TxValid), 32'h0);
      chk("arst_txdata", 32'(TxData), 32'h0);
      chk("arst_portout", PortOut, 32'h0);
      drive(IOB + 32'h8, 32'h0, 0, 1, 32'h0);
      chk("arst_status", ReadData, 32'h0000_0004);
      drive(IOB + 32'h4, 32'h0, 0, 1, 32'h0);
      chk("arst_portin", ReadData, 32'h0);
      sb_q.delete();
      m_ovf   = 1'b0;
      TxReady = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_hold_txvalid", 32'(TxValid), 32'h0);
      reset = 1'b1;
      drive(32'h0, 32'h0, 0, 0, 32'h0);
      step();
      chk("post_rst_txvalid", 32'(TxValid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
